upg_frame_loader: RTL and testbench

//  Upstream stage of the UART programmer (UPG) path: turns the UART receiver's byte stream into

---
 rtl/upg_frame_loader_pkg.sv | 16 +
 rtl/upg_frame_loader_if.sv | 16 +
 rtl/upg_word_assembler.sv | 31 +++
 rtl/upg_frame_loader.sv | 110 +++++++++++
 tb/tb_upg_frame_loader.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/upg_frame_loader_pkg.sv
// upg_frame_loader_pkg: shared FSM states and frame header bit positions for the UART programmer path.
package upg_frame_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    localparam int HDR_TGT  = 0;
    localparam int HDR_LAST = 7;

endpackage

// File: rtl/upg_frame_loader_if.sv
// upg_frame_loader_if: UART byte input plus the upg_* memory programming port and status flags.
interface upg_frame_loader_if #(parameter int ADDR_W = 14);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wen;
    logic [ADDR_W:0]   adr;
    logic [31:0]       dat;
    logic              done;
    logic              err;
    logic              busy;

    modport master (output rx_valid, rx_data, input wen, adr, dat, done, err, busy);
    modport slave  (input rx_valid, rx_data, output wen, adr, dat, done, err, busy);

endinterface

// File: rtl/upg_word_assembler.sv
// upg_word_assembler: packs four bytes (first byte = bits[7:0]) into a 32-bit word.
module upg_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        valid,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] sr;

    // word is complete in the cycle its 4th byte arrives; the caller registers it
    assign word       = {data, sr};
    assign word_valid = valid && lane == 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            sr   <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (valid) begin
            lane <= lane + 2'd1;
            sr   <= {data, sr[23:8]};
        end
    end

endmodule

// File: rtl/upg_frame_loader.sv
// upg_frame_loader: parses framed UART segments into word writes on the imem/dmem programming port.
module upg_frame_loader
    import upg_frame_loader_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               upg_clk,
    input  logic               upg_rstn,
    upg_frame_loader_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    logic             tgt;
    logic             last;
    logic [7:0]       cnt_lo;
    logic [7:0]       csum;
    logic [CNT_W+1:0] rem;
    logic [CNT_W-1:0] idx;
    logic [TW-1:0]    idle;
    logic [31:0]      word;
    logic             word_valid;
    logic             rx;
    logic             busy;
    logic             to;
    logic             ovf;

    assign rx       = bus.rx_valid;
    assign busy     = state != S_IDLE && state != S_DONE;
    assign to       = busy && !rx && idle == TW'(TIMEOUT_CYCLES - 1);
    assign ovf      = (idx >> ADDR_W) != '0;
    assign bus.busy = busy;

    upg_word_assembler u_asm (
        .clk        (upg_clk),
        .rst_n      (upg_rstn),
        .data       (bus.rx_data),
        .valid      (rx && state == S_DATA),
        .clear      (!busy || to),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge upg_clk or negedge upg_rstn) begin
        if (!upg_rstn) begin
            state    <= S_IDLE;
            tgt      <= 1'b0;
            last     <= 1'b0;
            cnt_lo   <= '0;
            csum     <= '0;
            rem      <= '0;
            idx      <= '0;
            idle     <= '0;
            bus.wen  <= 1'b0;
            bus.adr  <= '0;
            bus.dat  <= '0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.wen <= word_valid && !ovf;
            idle    <= rx ? '0 : busy ? idle + TW'(1) : idle;
            if (word_valid) begin
                idx <= idx + CNT_W'(1);
                if (ovf) bus.err <= 1'b1;
                else begin
                    bus.dat <= word;
                    bus.adr <= {tgt, idx[ADDR_W-1:0]};
                end
            end
            if (to) begin
                state   <= S_IDLE;
                bus.err <= 1'b1;
            end else if (rx) begin
                case (state)
                    S_IDLE: begin
                        tgt   <= bus.rx_data[HDR_TGT];
                        last  <= bus.rx_data[HDR_LAST];
                        idx   <= '0;
                        csum  <= '0;
                        state <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        cnt_lo <= bus.rx_data;
                        state  <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        rem   <= (CNT_W+2)'({bus.rx_data, cnt_lo}) << 2;
                        state <= {bus.rx_data, cnt_lo} == 16'd0 ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        csum  <= csum ^ bus.rx_data;
                        rem   <= rem - (CNT_W+2)'(1);
                        state <= rem == (CNT_W+2)'(1) ? S_CSUM : S_DATA;
                    end
                    S_CSUM: begin
                        // a bad checksum forces a resend; words already written are left in place
                        state    <= (csum == bus.rx_data && last) ? S_DONE : S_IDLE;
                        bus.done <= csum == bus.rx_data && last;
                        bus.err  <= bus.err || csum != bus.rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upg_frame_loader.sv
// tb_upg_frame_loader: directed frames with a write scoreboard checked by an independent monitor.
module tb_upg_frame_loader;

    localparam int ADDR_W = 14;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W:0] adr;
        logic [31:0]     dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    bq_t  f;

    always #5 clk = ~clk;

    upg_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

    upg_frame_loader #(
        .ADDR_W         (ADDR_W),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .upg_clk  (clk),
        .upg_rstn (rst_n),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_all(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic expect_wr(input logic tgt, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.adr = {tgt, a};
        w.dat = d;
        exp_q.push_back(w);
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({bus.wen, bus.adr, bus.dat, bus.done, bus.err, bus.busy}), 64'd0);
    endtask

    task automatic check_status(input string name, input logic [2:0] exp);
        check(name, 64'({bus.done, bus.err, bus.busy}), 64'(exp));
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: got adr=%h dat=%h expected no write", bus.adr, bus.dat);
            end else begin
                e = exp_q.pop_front();
                check("wr_adr", 64'(bus.adr), 64'(e.adr));
                check("wr_dat", 64'(bus.dat), 64'(e.dat));
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        expect_wr(1'b0, 14'd0, 32'h1234_5678);
        expect_wr(1'b0, 14'd1, 32'hDEAD_BEEF);
        send(8'h00);
        check("busy_after_hdr", 64'(bus.busy), 64'd1);
        f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_all(f);
        check_status("imem_frame", 3'b000);

        expect_wr(1'b1, 14'd0, 32'h0000_0001);
        f = '{8'h81, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(f);
        check_status("bad_csum", 3'b010);

        expect_wr(1'b1, 14'd0, 32'h0000_0001);
        f = '{8'h81, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        send_all(f);
        check_status("resend_done", 3'b110);

        f = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_all(f);
        check_status("done_terminal", 3'b110);

        rst_n = 1'b0;
        #1;
        check_zero("reset_after_done");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        f = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_all(f);
        repeat (49) @(posedge clk);
        #1;
        check("busy_before_timeout", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        check_status("timeout", 3'b010);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        f = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_all(f);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_frame");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        expect_wr(1'b0, 14'd0, 32'h1122_3344);
        f = '{8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        send_all(f);
        check_status("refill_after_reset", 3'b000);

        f = '{8'h80, 8'h00, 8'h00, 8'h00};
        send_all(f);
        check_status("count_zero_last", 3'b100);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
